// File: rtl/fp_mul_core.sv
// fp_mul_core: iterative binary32 multiplier datapath (shift-add, normalise, round, classify)
// Ports: clk, rst_n (async active-low); start, a, b in;
//   busy, done, sign_out, M_out, E_out, required_shift,
//   overflow_flag, underflow_flag, invalid_flag out.
// Config: define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_mul_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        sign_out,
  output logic [23:0] M_out,
  output logic [7:0]  E_out,
  output logic [7:0]  required_shift,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        invalid_flag
);
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
  state_t state, state_nx;
  logic [47:0] p;
  logic [23:0] ma;
  logic signed [9:0] e;
  logic sgn;
  logic [4:0] cnt;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inv, ovf_sp, special;
  logic [9:0] e0;
  logic [24:0] sum;
  logic hi, ovf_n, unf_n, deep;
  logic [23:0] sig, r;
  logic signed [9:0] en;
  // denormal inputs have E=0 and are treated as zero
  assign a_zero = a[30:23] == 8'd0;
  assign b_zero = b[30:23] == 8'd0;
  assign a_inf = &a[30:23] && a[22:0] == 23'd0;
  assign b_inf = &b[30:23] && b[22:0] == 23'd0;
  assign a_nan = &a[30:23] && a[22:0] != 23'd0;
  assign b_nan = &b[30:23] && b[22:0] != 23'd0;
  assign inv = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
  assign ovf_sp = !inv & (a_inf | b_inf);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign e0 = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
  // low half of p holds the multiplier and drains as the product fills the top
  assign sum = {1'b0, p[47:24]} + {1'b0, p[0] ? ma : 24'd0};
  assign hi = p[47];
  assign sig = hi ? p[47:24] : p[46:23];
`ifdef FPMUL_ROUND_NEAREST_EN
  logic grd, stk;
  logic [24:0] sum_r;
  assign grd = hi ? p[23] : p[22];
  assign stk = hi ? |p[22:0] : |p[21:0];
  assign sum_r = {1'b0, sig} + {24'd0, grd & (stk | sig[0])};
  assign r = sum_r[24] ? 24'h800000 : sum_r[23:0];
  assign en = e + {9'd0, hi} + {9'd0, sum_r[24]};
`else
  assign r = sig;
  assign en = e + {9'd0, hi};
`endif
  assign ovf_n = en >= 10'sd255;
  assign unf_n = en <= 10'sd0;
  // more than 24 places of denormal shift: force a downstream shift of exactly 24
  assign deep = en < -10'sd23;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (start ? (special ? DONE : MUL) : IDLE) :
               state == MUL  ? (cnt == 5'd23 ? NORM : MUL) :
               state == NORM ? DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p <= '0;
      ma <= '0;
      e <= '0;
      sgn <= 1'b0;
      cnt <= '0;
      sign_out <= 1'b0;
      M_out <= '0;
      E_out <= '0;
      required_shift <= '0;
      overflow_flag <= 1'b0;
      underflow_flag <= 1'b0;
      invalid_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        p <= {24'd0, 1'b1, b[22:0]};
        ma <= {1'b1, a[22:0]};
        e <= e0;
        sgn <= a[31] ^ b[31];
        cnt <= '0;
        if (special) begin
          sign_out <= a[31] ^ b[31];
          M_out <= '0;
          E_out <= (inv | ovf_sp) ? 8'hFF : 8'h00;
          required_shift <= '0;
          overflow_flag <= ovf_sp;
          underflow_flag <= 1'b0;
          invalid_flag <= inv;
        end
      end else if (state == MUL) begin
        p <= {sum, p[23:1]};
        cnt <= cnt + 5'd1;
      end else if (state == NORM) begin
        sign_out <= sgn;
        M_out <= ovf_n ? 24'd0 : r;
        E_out <= ovf_n ? 8'hFF : (unf_n && deep) ? 8'hE9 : en[7:0];
        required_shift <= {7'd0, unf_n};
        overflow_flag <= ovf_n;
        underflow_flag <= unf_n;
        invalid_flag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_core.sv
// tb_fp_mul_core: directed vector bench for fp_mul_core (latency, results, reset and start handshake)
module tb_fp_mul_core;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, sign_out, overflow_flag, underflow_flag, invalid_flag;
  logic [23:0] M_out;
  logic [7:0] E_out, required_shift;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [31:0] a, b;
    logic s;
    logic [23:0] m;
    logic [7:0] ex, rs;
    logic ov, un, inv;
    int lat;
  } vec_t;
  vec_t v[17];
  always #5 clk = ~clk;
  fp_mul_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sign_out(sign_out), .M_out(M_out), .E_out(E_out),
    .required_shift(required_shift), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag), .invalid_flag(invalid_flag)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input logic [31:0] ai, input logic [31:0] bi, output int lat);
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  initial begin
    int lat;
    logic [23:0] m_rnd;
`ifdef FPMUL_ROUND_NEAREST_EN
    m_rnd = 24'hC00002;
`else
    m_rnd = 24'hC00001;
`endif
    v[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 24'hC00000, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 25};
    v[1]  = '{32'h3F800001, 32'h3FC00000, 1'b0, m_rnd,      8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 25};
    v[2]  = '{32'h7F000000, 32'h7F000000, 1'b0, 24'h000000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 25};
    v[3]  = '{32'h00800000, 32'h3F000000, 1'b0, 24'h800000, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 25};
    v[4]  = '{32'h7F800000, 32'h00000000, 1'b0, 24'h000000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    v[5]  = '{32'h00000000, 32'h40000000, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
    v[6]  = '{32'hBF800000, 32'h40400000, 1'b1, 24'hC00000, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 25};
    v[7]  = '{32'h7F800000, 32'hC0000000, 1'b1, 24'h000000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    v[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 24'h000000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 0};
    v[9]  = '{32'h00000001, 32'h3F800000, 1'b0, 24'h000000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0};
    v[10] = '{32'h00800000, 32'h00800000, 1'b0, 24'h800000, 8'hE9, 8'h01, 1'b0, 1'b1, 1'b0, 25};
    v[11] = '{32'h00800000, 32'h3E800000, 1'b0, 24'h800000, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 25};
    v[12] = '{32'h00800000, 32'h33000000, 1'b0, 24'h800000, 8'hE9, 8'h01, 1'b0, 1'b1, 1'b0, 25};
    v[13] = '{32'h3FC00000, 32'h3FC00000, 1'b0, 24'h900000, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 25};
    v[14] = '{32'h7F400000, 32'h3FC00000, 1'b0, 24'h000000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 25};
    v[15] = '{32'h7F000000, 32'h3FC00000, 1'b0, 24'hC00000, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 25};
    v[16] = '{32'h7F800000, 32'hFF800000, 1'b1, 24'h000000, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset M_out", M_out, 0);
    chk("reset E_out", E_out, 0);
    chk("reset flags", {overflow_flag, underflow_flag, invalid_flag, sign_out}, 0);
    chk("reset required_shift", required_shift, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run(v[i].a, v[i].b, lat);
      $display("vec %0d: %h x %h", i, v[i].a, v[i].b);
      chk("latency", lat, v[i].lat);
      chk("sign_out", sign_out, v[i].s);
      chk("M_out", M_out, v[i].m);
      chk("E_out", E_out, v[i].ex);
      chk("required_shift", required_shift, v[i].rs);
      chk("overflow_flag", overflow_flag, v[i].ov);
      chk("underflow_flag", underflow_flag, v[i].un);
      chk("invalid_flag", invalid_flag, v[i].inv);
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("hold E_out", E_out, 8'hFF);
    chk("hold overflow_flag", overflow_flag, 1);
    chk("hold sign_out", sign_out, 1);
    chk("idle busy", busy, 0);
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset M_out", M_out, 0);
    chk("midreset E_out", E_out, 0);
    chk("midreset flags", {overflow_flag, underflow_flag, invalid_flag, sign_out}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    a = 32'h3FC00000;
    b = 32'h3FC00000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 5) begin
        start = 1'b1;
        a = 32'h7F800000;
        b = 32'h00000000;
      end else start = 1'b0;
    end
    chk("restart latency", lat, 25);
    chk("restart M_out", M_out, 24'h900000);
    chk("restart E_out", E_out, 8'h80);
    chk("restart invalid_flag", invalid_flag, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start in DONE busy", busy, 0);
    chk("start in DONE done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ignored start busy", busy, 0);
    chk("ignored start M_out", M_out, 24'h900000);
    chk("ignored start invalid_flag", invalid_flag, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
